// File: rtl/alu_mc.sv
// Execute-stage ALU with a valid/ready front end. Single-cycle ARM data-processing ops
// register their result in one cycle; MUL/MLA run an iterative shift-add multiplier.
module alu_mc #(
  parameter int WIDTH      = 32,
  parameter bit MUL_ENABLE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_command,
  input  logic [WIDTH-1:0] alu_in1,
  input  logic [WIDTH-1:0] alu_in2,
  input  logic [WIDTH-1:0] alu_in3,
  input  logic [3:0]       status_register,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [3:0]       alu_status_register_out,
  output logic             alu_illegal,
  output logic [1:0]       fsm_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MUL = 4'b1010;
  localparam logic [3:0] CMD_MLA = 4'b1011;
  localparam logic [3:0] CMD_CMP = 4'b1100;
  localparam logic [3:0] CMD_TST = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  // Handshake: a command transfers on an edge where in_valid & in_ready; a result is
  // consumed on an edge where out_valid & out_ready. in_ready is low for the whole MULT.
  logic xfer;
  logic is_mul_cmd;

  assign in_ready   = (state == IDLE) | ((state == DONE) & out_ready);
  assign xfer       = in_valid & in_ready;
  assign is_mul_cmd = MUL_ENABLE & ((alu_command == CMD_MUL) | (alu_command == CMD_MLA));
  assign fsm_state  = state;

  // Multiplier state
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc, mcand, mplier, addend;
  logic             mla, cap_c, cap_v;
  logic [WIDTH-1:0] mul_step, mul_result;
  logic [3:0]       mul_flags;

  assign mul_step   = acc + (mplier[0] ? mcand : '0);
  assign mul_result = mul_step + (mla ? addend : '0);
  assign mul_flags  = {~|mul_result, cap_c, mul_result[WIDTH-1], cap_v};

  // Single-cycle datapath, evaluated directly on the transferring operands
  logic [WIDTH-1:0] sc_result;
  logic [3:0]       sc_flags;
  logic             sc_illegal;
  logic [WIDTH:0]   sum;
  logic             arith, ovf;

  always_comb begin
    sc_result  = '0;
    sc_flags   = status_register;
    sc_illegal = 1'b0;
    sum        = '0;
    arith      = 1'b0;
    ovf        = 1'b0;
    case (alu_command)
      CMD_MOV: sc_result = alu_in2;
      CMD_MVN: sc_result = ~alu_in2;
      CMD_ADD, CMD_ADC: begin
        arith     = 1'b1;
        sum       = {1'b0, alu_in1} + {1'b0, alu_in2}
                  + {{WIDTH{1'b0}}, (alu_command == CMD_ADC) & status_register[2]};
        sc_result = sum[WIDTH-1:0];
        ovf       = (alu_in1[WIDTH-1] == alu_in2[WIDTH-1]) & (sum[WIDTH-1] != alu_in1[WIDTH-1]);
      end
      CMD_SUB, CMD_CMP, CMD_SBC: begin
        arith     = 1'b1;
        sum       = {1'b0, alu_in1} + {1'b0, ~alu_in2}
                  + {{WIDTH{1'b0}}, (alu_command == CMD_SBC) ? status_register[2] : 1'b1};
        sc_result = sum[WIDTH-1:0];
        ovf       = (alu_in1[WIDTH-1] != alu_in2[WIDTH-1]) & (sum[WIDTH-1] != alu_in1[WIDTH-1]);
      end
      CMD_AND, CMD_TST: sc_result = alu_in1 & alu_in2;
      CMD_ORR: sc_result = alu_in1 | alu_in2;
      CMD_EOR: sc_result = alu_in1 ^ alu_in2;
      default: sc_illegal = 1'b1;
    endcase
    // Illegal commands report the incoming flags untouched
    if (!sc_illegal) begin
      sc_flags = {~|sc_result,
                  arith ? sum[WIDTH] : status_register[2],
                  sc_result[WIDTH-1],
                  arith ? ovf : status_register[0]};
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if ((state == DONE) && out_ready) state_next = IDLE;
        if (xfer) state_next = is_mul_cmd ? MULT : DONE;
      end
      MULT: if (count == LAST) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid               <= 1'b0;
      alu_out                 <= '0;
      alu_status_register_out <= '0;
      alu_illegal             <= 1'b0;
      count                   <= '0;
      acc                     <= '0;
      mcand                   <= '0;
      mplier                  <= '0;
      addend                  <= '0;
      mla                     <= 1'b0;
      cap_c                   <= 1'b0;
      cap_v                   <= 1'b0;
    end else if (xfer) begin
      if (is_mul_cmd) begin
        mcand     <= alu_in1;
        mplier    <= alu_in2;
        addend    <= alu_in3;
        mla       <= alu_command[0];
        cap_c     <= status_register[2];
        cap_v     <= status_register[0];
        acc       <= '0;
        count     <= '0;
        out_valid <= 1'b0;
      end else begin
        alu_out                 <= sc_result;
        alu_status_register_out <= sc_flags;
        alu_illegal             <= sc_illegal;
        out_valid               <= 1'b1;
      end
    end else if (state == MULT) begin
      // One conditional add per cycle, multiplicand walking left, multiplier right
      acc    <= mul_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + CW'(1);
      if (count == LAST) begin
        count                   <= '0;
        alu_out                 <= mul_result;
        alu_status_register_out <= mul_flags;
        alu_illegal             <= 1'b0;
        out_valid               <= 1'b1;
      end
    end else if ((state == DONE) && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: directed checks from the block's worked examples plus randomized
// commands compared against an arithmetic reference model.
module tb_alu_mc;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready, alu_illegal;
  logic [3:0]   alu_command, status_register, alu_status_register_out;
  logic [W-1:0] alu_in1, alu_in2, alu_in3, alu_out;
  logic [1:0]   fsm_state;

  int total = 0;
  int bad   = 0;
  logic [W+4:0] exp_q[$];

  alu_mc #(.WIDTH(W), .MUL_ENABLE(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_command(alu_command), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_in3(alu_in3),
    .status_register(status_register), .out_valid(out_valid), .out_ready(out_ready),
    .alu_out(alu_out), .alu_status_register_out(alu_status_register_out),
    .alu_illegal(alu_illegal), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  function automatic longint sgn(input logic [W-1:0] x);
    longint v;
    v = longint'(x);
    return x[W-1] ? v - (longint'(1) <<< W) : v;
  endfunction

  // Reference: {illegal, Z, C, N, V, result}
  function automatic logic [W+4:0] model(input logic [3:0] cmd, input logic [W-1:0] a, b, c,
                                         input logic [3:0] f);
    longint unsigned ua, ub, full;
    longint sr, smax, smin;
    logic [W-1:0] r;
    logic cy, ov, arith, ill, ci, bw;
    ua = a; ub = b; full = 0; sr = 0; r = '0;
    cy = f[2]; ov = f[0]; arith = 1'b0; ill = 1'b0; ci = 1'b0; bw = 1'b0;
    smax = (longint'(1) <<< (W-1)) - 1;
    smin = -(longint'(1) <<< (W-1));
    case (cmd)
      4'b0001: r = b;
      4'b1001: r = ~b;
      4'b0010, 4'b0011: begin
        ci = (cmd == 4'b0011) ? f[2] : 1'b0;
        full = ua + ub + ci; r = full[W-1:0]; arith = 1'b1;
        cy = (full >> W) != 0;
        sr = sgn(a) + sgn(b) + ci; ov = (sr > smax) || (sr < smin);
      end
      4'b0100, 4'b1100, 4'b0101: begin
        bw = (cmd == 4'b0101) ? !f[2] : 1'b0;
        r = a - b - bw; arith = 1'b1;
        cy = ua >= ub + bw;
        sr = sgn(a) - sgn(b) - bw; ov = (sr > smax) || (sr < smin);
      end
      4'b0110, 4'b1101: r = a & b;
      4'b0111: r = a | b;
      4'b1000: r = a ^ b;
      4'b1010: begin full = ua * ub; r = full[W-1:0]; end
      4'b1011: begin full = ua * ub + longint'(c); r = full[W-1:0]; end
      default: ill = 1'b1;
    endcase
    if (ill) return {1'b1, f, {W{1'b0}}};
    return {1'b0, r == '0, arith ? cy : f[2], r[W-1], arith ? ov : f[0], r};
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_idle;
    in_valid = 1'b0; alu_command = 4'b0000; alu_in1 = '0; alu_in2 = '0; alu_in3 = '0;
    status_register = 4'b0000;
  endtask

  task automatic reset_dut;
    @(negedge clk);
    rst = 1'b0; drive_idle(); out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Presents one command at a negedge; returns in_ready seen before the edge.
  task automatic send(input logic [3:0] cmd, input logic [W-1:0] a, b, c,
                      input logic [3:0] f, output logic rdy);
    alu_command = cmd; alu_in1 = a; alu_in2 = b; alu_in3 = c; status_register = f;
    in_valid = 1'b1;
    #1 rdy = in_ready;
    @(negedge clk);
    in_valid = 1'b0;
    alu_in1 = $urandom; alu_in2 = $urandom; alu_in3 = $urandom;
    status_register = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_result(output int n, output logic busy_ok);
    n = 0; busy_ok = 1'b1;
    while (out_valid !== 1'b1 && n < W + 8) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset_dut();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (alu_out !== '0) begin bad++; $display("FAIL reset_out got=%h exp=0", alu_out); end
    total++; if (alu_status_register_out !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0000", alu_status_register_out); end
    total++; if (alu_illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%b exp=0", alu_illegal); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    total++; if (fsm_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", fsm_state); end
  endtask

  task automatic test_add_overflow;
    logic rdy;
    out_ready = 1'b1;
    send(4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h0, 4'b0000, rdy);
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL add_ready got=%b exp=1", rdy); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b exp=1", out_valid); end
    total++; if (alu_out !== 32'h8000_0000) begin bad++; $display("FAIL add_out got=%h exp=80000000", alu_out); end
    total++; if (alu_status_register_out !== 4'b0011) begin bad++; $display("FAIL add_flags got=%b exp=0011", alu_status_register_out); end
  endtask

  task automatic test_sub_sbc;
    logic rdy;
    send(4'b0100, 32'd5, 32'd5, 32'd0, 4'b0000, rdy);
    total++; if (alu_out !== 32'd0 || alu_status_register_out !== 4'b1100)
      begin bad++; $display("FAIL sub_eq got=%h/%b exp=0/1100", alu_out, alu_status_register_out); end
    send(4'b0101, 32'd0, 32'd0, 32'd0, 4'b0000, rdy);
    total++; if (alu_out !== 32'hFFFF_FFFF || alu_status_register_out !== 4'b0010)
      begin bad++; $display("FAIL sbc_zero got=%h/%b exp=ffffffff/0010", alu_out, alu_status_register_out); end
  endtask

  task automatic test_logic;
    logic rdy;
    send(4'b0110, 32'h0000_F0F0, 32'h0000_0F0F, 32'd0, 4'b0101, rdy);
    total++; if (alu_out !== 32'd0 || alu_status_register_out !== 4'b1101 || alu_illegal !== 1'b0)
      begin bad++; $display("FAIL and_pass got=%h/%b exp=0/1101", alu_out, alu_status_register_out); end
  endtask

  task automatic test_mul;
    logic rdy, busy_ok;
    int n;
    out_ready = 1'b1;
    send(4'b1010, 32'hFFFF_FFFF, 32'd3, 32'd0, 4'b0101, rdy);
    wait_result(n, busy_ok);
    total++; if (n !== W) begin bad++; $display("FAIL mul_latency got=%0d exp=%0d", n, W); end
    total++; if (busy_ok !== 1'b1) begin bad++; $display("FAIL mul_busy got=%b exp=1", busy_ok); end
    total++; if (alu_out !== 32'hFFFF_FFFD || alu_status_register_out !== 4'b0111)
      begin bad++; $display("FAIL mul_out got=%h/%b exp=fffffffd/0111", alu_out, alu_status_register_out); end
    send(4'b1011, 32'd6, 32'd7, 32'd8, 4'b0000, rdy);
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL mla_ready got=%b exp=1", rdy); end
    wait_result(n, busy_ok);
    total++; if (n !== W || alu_out !== 32'd50 || alu_status_register_out !== 4'b0000)
      begin bad++; $display("FAIL mla_out got=%0d/%h/%b exp=%0d/32/0000", n, alu_out, alu_status_register_out, W); end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mla_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure;
    logic rdy;
    out_ready = 1'b0;
    send(4'b0010, 32'd10, 32'd20, 32'd0, 4'b0000, rdy);
    alu_command = 4'b0100; alu_in1 = 32'd99; alu_in2 = 32'd1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (out_valid !== 1'b1 || alu_out !== 32'd30 || alu_status_register_out !== 4'b0000 || in_ready !== 1'b0)
        begin bad++; $display("FAIL stall_hold[%0d] got=%b/%h/%b/%b exp=1/1e/0000/0", i, out_valid, alu_out, alu_status_register_out, in_ready); end
      @(negedge clk);
    end
    out_ready = 1'b1; alu_command = 4'b1000; alu_in1 = 32'hFF; alu_in2 = 32'h0F; status_register = 4'b0000;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || alu_out !== 32'hF0 || alu_status_register_out !== 4'b0000)
      begin bad++; $display("FAIL release_out got=%b/%h/%b exp=1/f0/0000", out_valid, alu_out, alu_status_register_out); end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL release_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] sc_cmds[11] = '{4'b0001, 4'b1001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
                                4'b0110, 4'b0111, 4'b1000, 4'b1100, 4'b1101};
    logic [3:0] cmd, f;
    logic [W-1:0] a, b;
    logic [W+4:0] exp;
    logic rdy;
    out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      cmd = sc_cmds[$urandom_range(0, 10)];
      a = (i % 4 == 0) ? 32'h8000_0000 : $urandom;
      b = (i % 5 == 0) ? a : $urandom;
      f = 4'($urandom_range(0, 15));
      exp_q.push_back(model(cmd, a, b, '0, f));
      send(cmd, a, b, '0, f, rdy);
      exp = exp_q.pop_front();
      total++;
      if (rdy !== 1'b1 || out_valid !== 1'b1 || {alu_illegal, alu_status_register_out, alu_out} !== exp)
        begin bad++; $display("FAIL b2b[%0d] cmd=%b got=%b/%b/%h exp=%b/%h", i, cmd, rdy, alu_status_register_out, alu_out, exp[W+3:W], exp[W-1:0]); end
    end
  endtask

  task automatic test_illegal;
    logic rdy;
    send(4'b1111, 32'h1234, 32'h5678, 32'd0, 4'b1010, rdy);
    total++; if (alu_illegal !== 1'b1 || alu_out !== 32'd0 || alu_status_register_out !== 4'b1010)
      begin bad++; $display("FAIL illegal_1111 got=%b/%h/%b exp=1/0/1010", alu_illegal, alu_out, alu_status_register_out); end
    send(4'b0000, 32'hFFFF, 32'h1, 32'd0, 4'b0110, rdy);
    total++; if (alu_illegal !== 1'b1 || alu_out !== 32'd0 || alu_status_register_out !== 4'b0110)
      begin bad++; $display("FAIL illegal_0000 got=%b/%h/%b exp=1/0/0110", alu_illegal, alu_out, alu_status_register_out); end
    send(4'b0001, 32'd0, 32'd7, 32'd0, 4'b0000, rdy);
    total++; if (alu_illegal !== 1'b0 || alu_out !== 32'd7)
      begin bad++; $display("FAIL illegal_clear got=%b/%h exp=0/7", alu_illegal, alu_out); end
  endtask

  task automatic test_reset_mid_mult;
    logic rdy, leak;
    out_ready = 1'b1;
    send(4'b1010, $urandom, $urandom, 32'd0, 4'b1111, rdy);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    total++;
    if (out_valid !== 1'b0 || alu_out !== '0 || alu_status_register_out !== 4'b0 || alu_illegal !== 1'b0 || fsm_state !== 2'd0)
      begin bad++; $display("FAIL midmult_reset got=%b/%h/%b/%b/%0d exp=0/0/0000/0/0", out_valid, alu_out, alu_status_register_out, alu_illegal, fsm_state); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midmult_ready got=%b exp=1", in_ready); end
    leak = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) leak = 1'b1;
    end
    total++; if (leak !== 1'b0) begin bad++; $display("FAIL midmult_leak got=%b exp=0", leak); end
  endtask

  task automatic test_random;
    logic [3:0] cmd, f;
    logic [W-1:0] a, b, c;
    logic [W+4:0] exp;
    logic rdy, busy_ok;
    int n, lat, stall;
    for (int i = 0; i < 30; i++) begin
      cmd = 4'($urandom_range(0, 15));
      a = $urandom; b = (i % 3 == 0) ? 32'($urandom_range(0, 255)) : $urandom; c = $urandom;
      f = 4'($urandom_range(0, 15));
      exp = model(cmd, a, b, c, f);
      lat = (cmd == 4'b1010 || cmd == 4'b1011) ? W : 0;
      out_ready = 1'b0;
      send(cmd, a, b, c, f, rdy);
      wait_result(n, busy_ok);
      total++;
      if (rdy !== 1'b1 || n !== lat || {alu_illegal, alu_status_register_out, alu_out} !== exp)
        begin bad++; $display("FAIL rand[%0d] cmd=%b lat=%0d/%0d got=%b%b/%h exp=%b/%h", i, cmd, n, lat, alu_illegal, alu_status_register_out, alu_out, exp[W+4:W], exp[W-1:0]); end
      stall = $urandom_range(0, 2);
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || {alu_illegal, alu_status_register_out, alu_out} !== exp)
          begin bad++; $display("FAIL rand_hold[%0d] got=%b/%h exp=1/%h", i, out_valid, alu_out, exp[W-1:0]); end
      end
      out_ready = 1'b1;
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rand_drain[%0d] got=%b exp=0", i, out_valid); end
    end
  endtask

  initial begin
    rst = 1'b0; out_ready = 1'b1; drive_idle();
    test_reset();
    test_add_overflow();
    test_sub_sbc();
    test_logic();
    test_mul();
    test_backpressure();
    test_back_to_back();
    test_illegal();
    test_reset_mid_mult();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
